// File: rtl/multi_ball_engine_if.sv
// Bus between the frame-tick source, multi_ball_engine and vga_display.
// The master drives tick/pause/speeds; the slave (engine) drives positions and status.
interface multi_ball_engine_if #(
   parameter int NUM_BALLS = 4,
   parameter int POS_W     = 10,
   parameter int SPD_W     = 4
);
   logic                       tick;
   logic                       pause;
   logic [NUM_BALLS*SPD_W-1:0] speed_x;
   logic [NUM_BALLS*SPD_W-1:0] speed_y;
   logic [NUM_BALLS*POS_W-1:0] pos_x;
   logic [NUM_BALLS*POS_W-1:0] pos_y;
   logic [NUM_BALLS-1:0]       bounce;
   logic                       busy;
   logic                       update_done;
   logic                       overrun;

   modport master (
      output tick, pause, speed_x, speed_y,
      input  pos_x, pos_y, bounce, busy, update_done, overrun
   );

   modport slave (
      input  tick, pause, speed_x, speed_y,
      output pos_x, pos_y, bounce, busy, update_done, overrun
   );
endinterface

// File: rtl/multi_ball_engine.sv
// Multi-ball position engine: on each frame tick, steps one ball per clock into shadow
// registers, then publishes all positions in a single cycle so the display never tears.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a tick (ignored while pause is high)
// ST_UPDATE  | stepping ball idx into the shadow registers, one per cycle
// ST_PUBLISH | shadow copied to published outputs; update_done and bounce valid
module multi_ball_engine #(
   parameter int NUM_BALLS = 4,
   parameter int H_DISP    = 640,
   parameter int V_DISP    = 480,
   parameter int BALL_SIZE = 16,
   parameter int POS_W     = 10,
   parameter int SPD_W     = 4
) (
   input logic clk,
   input logic rst,
   multi_ball_engine_if.slave bus
);
   localparam int XL    = H_DISP - BALL_SIZE;
   localparam int YL    = V_DISP - BALL_SIZE;
   localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_PUBLISH} state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [POS_W-1:0]     sh_x  [NUM_BALLS];
   logic [POS_W-1:0]     sh_y  [NUM_BALLS];
   logic [POS_W-1:0]     pub_x [NUM_BALLS];
   logic [POS_W-1:0]     pub_y [NUM_BALLS];
   logic [NUM_BALLS-1:0] dir_x, dir_y, bnc;
   logic                 overrun_q;
   logic [POS_W+1:0]     step_x, step_y;
   logic [NUM_BALLS*POS_W-1:0] px_flat, py_flat;

   // Returns {hit, new_dir, new_pos}; dir 1 means moving toward zero.
   function automatic logic [POS_W+1:0] axis_step(input logic [POS_W-1:0] p,
                                                  input logic [SPD_W-1:0] s,
                                                  input logic             d,
                                                  input logic [POS_W-1:0] lim);
      logic [POS_W:0]   n;
      logic [POS_W+1:0] r;
      n = {1'b0, p} + (POS_W+1)'(s);
      r = {1'b0, d, p};
      if (s != '0) begin
         if (!d) begin
            if (n >= {1'b0, lim}) r = {1'b1, 1'b1, lim};
            else                  r = {1'b0, d, n[POS_W-1:0]};
         end else begin
            if ({1'b0, p} <= (POS_W+1)'(s)) r = {1'b1, 1'b0, {POS_W{1'b0}}};
            else                            r = {1'b0, d, p - POS_W'(s)};
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         ST_IDLE: begin
            if (bus.tick && !bus.pause) begin
               state_nxt = ST_UPDATE;
               idx_nxt   = '0;
            end
         end
         ST_UPDATE: begin
            if (idx == IDX_W'(NUM_BALLS - 1)) state_nxt = ST_PUBLISH;
            else                              idx_nxt   = idx + 1'b1;
         end
         ST_PUBLISH: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      step_x = axis_step(sh_x[idx], bus.speed_x[idx*SPD_W +: SPD_W], dir_x[idx], POS_W'(XL));
      step_y = axis_step(sh_y[idx], bus.speed_y[idx*SPD_W +: SPD_W], dir_y[idx], POS_W'(YL));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BALLS; i++) begin
            sh_x[i]  <= POS_W'(i * (H_DISP / NUM_BALLS));
            sh_y[i]  <= POS_W'(i * (V_DISP / NUM_BALLS));
            pub_x[i] <= POS_W'(i * (H_DISP / NUM_BALLS));
            pub_y[i] <= POS_W'(i * (V_DISP / NUM_BALLS));
            dir_x[i] <= 1'(i % 2);
            dir_y[i] <= 1'b0;
         end
         bnc       <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (bus.tick && (state != ST_IDLE)) overrun_q <= 1'b1;
         if (state == ST_UPDATE) begin
            sh_x[idx]  <= step_x[POS_W-1:0];
            sh_y[idx]  <= step_y[POS_W-1:0];
            dir_x[idx] <= step_x[POS_W];
            dir_y[idx] <= step_y[POS_W];
            bnc[idx]   <= step_x[POS_W+1] | step_y[POS_W+1];
         end
         if (state == ST_PUBLISH) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
               pub_x[i] <= sh_x[i];
               pub_y[i] <= sh_y[i];
            end
         end
      end
   end

   always_comb begin
      px_flat = '0;
      py_flat = '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
         px_flat[i*POS_W +: POS_W] = pub_x[i];
         py_flat[i*POS_W +: POS_W] = pub_y[i];
      end
   end

   assign bus.pos_x       = px_flat;
   assign bus.pos_y       = py_flat;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.update_done = (state == ST_PUBLISH);
   assign bus.bounce      = (state == ST_PUBLISH) ? bnc : '0;
   assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_multi_ball_engine.sv
// Bench for multi_ball_engine: table of multi-tick vectors against a reference model
// with a frame scoreboard, plus hand sequences for latency, overrun, pause and reset.
module tb_multi_ball_engine;
   localparam int N  = 4;
   localparam int PW = 10;
   localparam int SW = 4;
   localparam int XL = 624;
   localparam int YL = 464;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multi_ball_engine_if #(.NUM_BALLS(N), .POS_W(PW), .SPD_W(SW)) bus ();
   multi_ball_engine #(.NUM_BALLS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [N*PW-1:0] px;
      logic [N*PW-1:0] py;
      logic [N-1:0]    b;
   } frame_t;

   typedef struct {
      logic [N*SW-1:0] sx;
      logic [N*SW-1:0] sy;
      int              ticks;
      int              ball;
      int              ex;
      int              ey;
      logic            eb;
   } vec_t;

   frame_t   sb_q[$];
   frame_t   cur;
   int       checks = 0;
   int       errors = 0;
   int       frames_seen = 0;
   bit       pos_pending = 0;
   logic [N-1:0] last_bounce = '0;
   int       mx[N], my[N], mdx[N], mdy[N];
   vec_t     tbl[11];

   localparam logic [N*PW-1:0] RST_PX = {10'd480, 10'd320, 10'd160, 10'd0};
   localparam logic [N*PW-1:0] RST_PY = {10'd360, 10'd240, 10'd120, 10'd0};

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic logic [N*SW-1:0] pk(int s0, int s1, int s2, int s3);
      return {4'(s3), 4'(s2), 4'(s1), 4'(s0)};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i] = i * (640 / N);
         my[i] = i * (480 / N);
         mdx[i] = i % 2;
         mdy[i] = 0;
      end
   endfunction

   function automatic void axis(inout int p, inout int d, input int s, input int lim,
                                output bit hit);
      hit = 0;
      if (s == 0) return;
      if (d == 0) begin
         if (p + s >= lim) begin p = lim; d = 1; hit = 1; end
         else p = p + s;
      end else begin
         if (p <= s) begin p = 0; d = 0; hit = 1; end
         else p = p - s;
      end
   endfunction

   function automatic frame_t model_tick(logic [N*SW-1:0] sx, logic [N*SW-1:0] sy);
      frame_t f;
      bit hx, hy;
      for (int i = 0; i < N; i++) begin
         axis(mx[i], mdx[i], int'(sx[i*SW +: SW]), XL, hx);
         axis(my[i], mdy[i], int'(sy[i*SW +: SW]), YL, hy);
         f.px[i*PW +: PW] = PW'(mx[i]);
         f.py[i*PW +: PW] = PW'(my[i]);
         f.b[i]           = hx | hy;
      end
      sb_q.push_back(f);
      return f;
   endfunction

   always @(negedge clk) begin
      if (pos_pending) begin
         chk("sb_pos_x", longint'(bus.pos_x), longint'(cur.px));
         chk("sb_pos_y", longint'(bus.pos_y), longint'(cur.py));
         pos_pending = 0;
      end
      if (bus.update_done === 1'b1) begin
         frames_seen++;
         last_bounce = bus.bounce;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done: got update_done with no frame expected");
         end else begin
            cur = sb_q.pop_front();
            chk("sb_bounce", longint'(bus.bounce), longint'(cur.b));
            pos_pending = 1;
         end
      end
   end

   task automatic run_frame(logic [N*SW-1:0] sx, logic [N*SW-1:0] sy);
      int  f0;
      frame_t f;
      bit  seen;
      f0 = frames_seen;
      seen = 0;
      @(negedge clk);
      bus.speed_x = sx;
      bus.speed_y = sy;
      bus.tick    = 1'b1;
      f = model_tick(sx, sy);
      @(negedge clk);
      bus.tick = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (frames_seen != f0) begin seen = 1; break; end
         @(negedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: no update_done within 20 cycles");
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [N*PW-1:0] p0;
      frame_t f;
      int f0;

      rst = 1'b1;
      bus.tick = 1'b0;
      bus.pause = 1'b0;
      bus.speed_x = '0;
      bus.speed_y = '0;
      model_reset();

      tbl[0]  = '{pk(15,3,0,7), pk(0,2,0,9), 41, 0, 615, 0, 1'b0};
      tbl[1]  = '{pk(5,3,0,7),  pk(0,2,0,9), 1,  0, 620, 0, 1'b0};
      tbl[2]  = '{pk(8,3,0,7),  pk(0,2,0,9), 1,  0, 624, 0, 1'b1};
      tbl[3]  = '{pk(8,3,0,7),  pk(0,2,0,9), 1,  0, 616, 0, 1'b0};
      tbl[4]  = '{pk(15,3,0,7), pk(0,2,0,9), 40, 0, 16,  0, 1'b0};
      tbl[5]  = '{pk(11,3,0,7), pk(0,2,0,9), 1,  0, 5,   0, 1'b0};
      tbl[6]  = '{pk(5,3,0,7),  pk(0,2,0,9), 1,  0, 0,   0, 1'b1};
      tbl[7]  = '{pk(5,3,0,7),  pk(0,2,0,9), 1,  0, 5,   0, 1'b0};
      tbl[8]  = '{pk(0,3,15,7), pk(0,2,11,9), 20, 2, 620, 460, 1'b0};
      tbl[9]  = '{pk(0,3,8,7),  pk(0,2,8,9),  1,  2, 624, 464, 1'b1};
      tbl[10] = '{pk(0,3,0,7),  pk(0,2,0,9),  1,  2, 624, 464, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_pos_x", longint'(bus.pos_x), longint'(RST_PX));
      chk("rst_pos_y", longint'(bus.pos_y), longint'(RST_PY));
      chk("rst_busy", bus.busy, 0);
      chk("rst_overrun", bus.overrun, 0);
      chk("rst_bounce", bus.bounce, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[e]) begin
         for (int t = 0; t < tbl[e].ticks; t++) run_frame(tbl[e].sx, tbl[e].sy);
         chk($sformatf("vec%0d_x", e), bus.pos_x[tbl[e].ball*PW +: PW], tbl[e].ex);
         chk($sformatf("vec%0d_y", e), bus.pos_y[tbl[e].ball*PW +: PW], tbl[e].ey);
         chk($sformatf("vec%0d_bounce", e), last_bounce[tbl[e].ball], tbl[e].eb);
      end

      // pause: tick is ignored and does not raise overrun
      f0 = frames_seen;
      bus.pause = 1'b1;
      bus.tick  = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      chk("pause_busy", bus.busy, 0);
      repeat (8) @(negedge clk);
      chk("pause_no_frame", frames_seen, f0);
      chk("pause_overrun", bus.overrun, 0);
      bus.pause = 1'b0;

      // latency, atomicity, overrun and earliest re-tick
      p0 = bus.pos_x;
      bus.speed_x = pk(1, 2, 3, 4);
      bus.speed_y = pk(4, 3, 2, 1);
      bus.tick    = 1'b1;
      f = model_tick(bus.speed_x, bus.speed_y);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk($sformatf("lat_busy_T%0d", k), bus.busy, (k <= 5 || k == 7) ? 1 : 0);
         chk($sformatf("lat_done_T%0d", k), bus.update_done, (k == 5) ? 1 : 0);
         chk($sformatf("lat_overrun_T%0d", k), bus.overrun, (k >= 3) ? 1 : 0);
         if (k <= 5) chk($sformatf("lat_hold_T%0d", k), longint'(bus.pos_x), longint'(p0));
         if (k == 6) chk("lat_new_pos", longint'(bus.pos_x), longint'(f.px));
         bus.tick = (k == 2 || k == 6) ? 1'b1 : 1'b0;
         if (k == 6) f = model_tick(bus.speed_x, bus.speed_y);
      end
      repeat (8) @(negedge clk);
      chk("overrun_sticky", bus.overrun, 1);

      // reset in the middle of an update aborts the frame
      f0 = frames_seen;
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      model_reset();
      chk("mid_rst_pos_x", longint'(bus.pos_x), longint'(RST_PX));
      chk("mid_rst_pos_y", longint'(bus.pos_y), longint'(RST_PY));
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_overrun", bus.overrun, 0);
      repeat (8) @(negedge clk);
      chk("mid_rst_no_done", frames_seen, f0);

      run_frame(pk(2, 6, 0, 1), pk(1, 0, 5, 3));
      chk("post_rst_ball1_x", bus.pos_x[1*PW +: PW], 154);
      chk("sb_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/multi_ball_engine.md
Name: multi_ball_engine

Overview:
Parametrised successor to the single pinball position generator. Maintains NUM_BALLS independent balls, each with its own position, direction and per-axis speed, and bounces them off the screen edges. Updates run once per frame tick, processing one ball per clock. Results are published atomically so vga_display never sees a half-updated frame. Sits between the frame-tick source and vga_display, running in the clk_vga domain.

Parameters:
NUM_BALLS, 4, number of balls (1..16)
H_DISP, 640, horizontal active pixels
V_DISP, 480, vertical active lines
BALL_SIZE, 16, ball square side in pixels; x limit XL = H_DISP-BALL_SIZE, y limit YL = V_DISP-BALL_SIZE
POS_W, 10, position width; must hold H_DISP
SPD_W, 4, speed width per axis; 2^SPD_W-1 must be < min(XL,YL)

Ports:
clk  in  1  clock (clk_vga)
rst  in  1  synchronous reset, active-high
tick  in  1  one-cycle frame-update request
pause  in  1  when high, ticks are ignored
speed_x  in  NUM_BALLS*SPD_W  per-ball x speed; ball i occupies bits [i*SPD_W +: SPD_W]
speed_y  in  NUM_BALLS*SPD_W  per-ball y speed, same packing
pos_x  out  NUM_BALLS*POS_W  published x of each ball (top-left corner), packed as for speed_x
pos_y  out  NUM_BALLS*POS_W  published y of each ball, same packing
bounce  out  NUM_BALLS  per-ball flag: that ball hit any wall in the last update; valid only while update_done=1
busy  out  1  update in progress
update_done  out  1  one-cycle pulse when a new frame is published
overrun  out  1  sticky error flag: a tick arrived while busy; cleared only by rst

Behaviour:
- Reset values (sync rst, priority over everything):
  - Ball i: x = i*(H_DISP/NUM_BALLS), y = i*(V_DISP/NUM_BALLS).
  - dir_x = i[0] (1 = moving negative); dir_y = 0 (moving positive).
  - Shadow and published registers both hold these values.
  - busy=0, update_done=0, bounce=0, overrun=0, FSM in IDLE.
- FSM states: IDLE, UPDATE, PUBLISH.
  - IDLE -> UPDATE on tick=1 && pause=0; ball index idx=0.
  - UPDATE: one ball (idx) per cycle, written to the shadow registers.
    - idx==NUM_BALLS-1 -> PUBLISH; otherwise idx+1.
  - PUBLISH: copy shadow to pos_x/pos_y; update_done=1 and bounce vector valid for this one cycle; -> IDLE.
- Timing: tick at cycle T gives busy=1 in cycles T+1..T+NUM_BALLS+1, and update_done at T+NUM_BALLS+1.
  - busy=0 again at T+NUM_BALLS+2.
  - The earliest accepted next tick is at cycle T+NUM_BALLS+2.
- Per-axis update, shown for x; y is identical with YL. Use s = speed_x slice, sampled in the ball's UPDATE cycle, and POS_W+1-bit arithmetic.
  - Positive direction:
    - n = x+s.
    - If n >= XL: x=XL, flip dir, bounce flag set.
    - Else: x=n.
  - Negative direction:
    - If x <= s: x=0, flip dir, bounce flag set.
    - Else: x = x-s.
  - s==0: position and direction unchanged, no bounce, including when the ball sits exactly on a wall.
- bounce[i] = x-bounce OR y-bounce. A corner hit flips both directions in the same update.
- Ticks while busy:
  - The tick is ignored; the FSM is unaffected.
  - overrun is set.
- Ticks while pause=1: ignored, no overrun. Pause has no effect on an update already in progress.
- Reset mid-update: everything returns to reset values next cycle; no update_done is produced for the aborted frame.
- pos_x/pos_y change only in the PUBLISH cycle. They are stable at all other times.

Test Plan:
- Reset, NUM_BALLS=4 defaults -> pos_x = {480,320,160,0} (ball3..ball0), pos_y = {360,240,120,0}, busy=0, overrun=0.
- Right wall: ball0 x=620 moving positive, speed_x=8, one tick -> x=624 (XL), bounce[0]=1 at update_done. Next tick -> x=616, bounce[0]=0.
- Left wall plus corner:
  - Ball moving negative at x=5, speed_x=5 -> x=0, dir flips.
  - Ball at (620,460) moving +/+, speeds 8/8 -> (624,464), both directions flip, bounce=1.
- Latency and atomicity: tick at cycle 10 -> busy high cycles 11..15, update_done at cycle 15; pos_x unchanged at cycles 11..14 and new at cycle 16.
- Tick at cycle 12 during busy -> ignored, overrun=1 and held. A second tick at cycle 17 is accepted normally. With pause=1, a tick -> no busy, no overrun.
- rst asserted at cycle 13 mid-update -> cycle 14 shows reset values, no update_done; speed=0 ball on a wall -> unchanged, bounce=0.
